dec_button_conditioner: RTL and testbench

//  Conditions the raw DEC push-button before it reaches the 0-59 counter top level.

---
 rtl/dec_button_conditioner.sv | 146 ++++++++++++++
 tb/tb_dec_button_conditioner.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_button_conditioner.sv
// DEC push-button conditioner: synchronise, debounce on a slow tick,
// classify short/long presses and toggle the DEC level on short presses.
module dec_button_conditioner #(
  parameter int TICK_DIV   = 4096,
  parameter int DEB_TICKS  = 8,
  parameter int LONG_TICKS = 700
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN_RAW,
  output logic DEC,
  output logic PRESS_PULSE,
  output logic LONG_PULSE,
  output logic BTN_STABLE
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    LONG_HELD,
    DEB_RELEASE
  } state_t;

  logic [1:0]    sync_q;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          btn_s;
  logic          tick;

  state_t        state_q;
  logic [DW-1:0] deb_q;
  logic [HW-1:0] hold_q;
  logic          long_flag_q;
  logic          dec_q;
  logic          press_q;
  logic          long_q;
  logic          stable_q;
  logic          deb_last;
  logic          hold_last;

  assign btn_s     = sync_q[1];
  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d   = tick ? '0 : presc_q + 1'b1;
  assign deb_last  = (deb_q == DW'(DEB_TICKS - 1));
  assign hold_last = (hold_q == HW'(LONG_TICKS - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q  <= '0;
      presc_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], BTN_RAW};
      presc_q <= presc_d;
    end
  end

  // A disagreeing btn_s always takes priority over a tick in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      deb_q       <= '0;
      hold_q      <= '0;
      long_flag_q <= 1'b0;
      dec_q       <= 1'b0;
      press_q     <= 1'b0;
      long_q      <= 1'b0;
      stable_q    <= 1'b0;
    end else begin
      press_q <= 1'b0;
      long_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          deb_q <= '0;
          if (btn_s) begin
            state_q <= DEB_PRESS;
            hold_q  <= '0;
          end
        end
        DEB_PRESS: begin
          if (!btn_s) begin
            state_q <= IDLE;
            deb_q   <= '0;
          end else if (tick) begin
            if (deb_last) begin
              state_q  <= HELD;
              deb_q    <= '0;
              press_q  <= 1'b1;
              stable_q <= 1'b1;
            end else begin
              deb_q <= deb_q + 1'b1;
            end
          end
        end
        HELD: begin
          if (!btn_s) begin
            state_q     <= DEB_RELEASE;
            long_flag_q <= 1'b0;
            deb_q       <= '0;
          end else if (tick) begin
            if (hold_q != HW'(LONG_TICKS))
              hold_q <= hold_q + 1'b1;
            if (hold_last) begin
              state_q <= LONG_HELD;
              long_q  <= 1'b1;
            end
          end
        end
        LONG_HELD: begin
          deb_q <= '0;
          if (!btn_s) begin
            state_q     <= DEB_RELEASE;
            long_flag_q <= 1'b1;
          end
        end
        DEB_RELEASE: begin
          if (btn_s) begin
            state_q <= long_flag_q ? LONG_HELD : HELD;
            deb_q   <= '0;
          end else if (tick) begin
            if (deb_last) begin
              state_q  <= IDLE;
              deb_q    <= '0;
              stable_q <= 1'b0;
              if (!long_flag_q)
                dec_q <= ~dec_q;
            end else begin
              deb_q <= deb_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DEC         = dec_q;
  assign PRESS_PULSE = press_q;
  assign LONG_PULSE  = long_q;
  assign BTN_STABLE  = stable_q;

endmodule

// File: tb/tb_dec_button_conditioner.sv
// Bench for dec_button_conditioner: expected output events with exact
// cycle numbers are queued at stimulus time and matched against a monitor.
module tb_dec_button_conditioner;

  localparam int TD = 4;
  localparam int EV_PRESS = 0;
  localparam int EV_LONG  = 1;
  localparam int EV_DEC   = 2;
  localparam int EV_STB   = 3;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic CLK;
  logic RESET;
  logic BTN_RAW;
  logic DEC;
  logic PRESS_PULSE;
  logic LONG_PULSE;
  logic BTN_STABLE;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int k        = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  logic dec_p;
  logic stb_p;

  dec_button_conditioner #(
    .TICK_DIV  (4),
    .DEB_TICKS (3),
    .LONG_TICKS(10)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .BTN_RAW    (BTN_RAW),
    .DEC        (DEC),
    .PRESS_PULSE(PRESS_PULSE),
    .LONG_PULSE (LONG_PULSE),
    .BTN_STABLE (BTN_STABLE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Event monitor; outputs sampled 1 time unit after each rising edge.
  always @(posedge CLK) begin
    cyc++;
    #1;
    if (!RESET) begin
      if (PRESS_PULSE === 1'b1) obs_q.push_back('{EV_PRESS, cyc});
      if (LONG_PULSE === 1'b1)  obs_q.push_back('{EV_LONG, cyc});
      if (DEC !== dec_p)        obs_q.push_back('{EV_DEC, cyc});
      if (stb_p === 1'b1 && BTN_STABLE === 1'b0)
        obs_q.push_back('{EV_STB, cyc});
    end
    dec_p = DEC;
    stb_p = BTN_STABLE;
  end

  // First edge >= e on which the prescaler is at TD-1.
  function automatic int next_tick(int e);
    int t;
    t = e;
    while (((t - k) % TD) != TD - 1) t++;
    return t;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    k = cyc + 1;
  endtask

  // Press for hi cycles, release for lo cycles, queue expected events.
  task automatic drive_press(int hi, int lo, bit is_long);
    int p, q, e1, e2;
    BTN_RAW = 1'b1;
    p  = cyc + 1;
    e1 = next_tick(p + 3);
    exp_q.push_back('{EV_PRESS, e1 + 8});
    if (is_long) exp_q.push_back('{EV_LONG, e1 + 48});
    repeat (hi) @(negedge CLK);
    BTN_RAW = 1'b0;
    q  = cyc + 1;
    e2 = next_tick(q + 3);
    if (!is_long) exp_q.push_back('{EV_DEC, e2 + 8});
    exp_q.push_back('{EV_STB, e2 + 8});
    repeat (lo) @(negedge CLK);
  endtask

  task automatic test_reset();
    int t0, q, e2;
    ev_t e, o;
    RESET   = 1'b1;
    BTN_RAW = 1'b1;
    repeat (2) @(negedge CLK);
    checks += 4;
    if (DEC !== 1'b0) begin
      failures++; $display("FAIL rst_dec got=%b exp=0", DEC);
    end
    if (PRESS_PULSE !== 1'b0) begin
      failures++; $display("FAIL rst_press got=%b exp=0", PRESS_PULSE);
    end
    if (LONG_PULSE !== 1'b0) begin
      failures++; $display("FAIL rst_long got=%b exp=0", LONG_PULSE);
    end
    if (BTN_STABLE !== 1'b0) begin
      failures++; $display("FAIL rst_stable got=%b exp=0", BTN_STABLE);
    end
    RESET = 1'b0;
    t0 = cyc;
    k  = t0 + 1;
    exp_q.push_back('{EV_PRESS, t0 + 12});
    repeat (14) @(negedge CLK);
    BTN_RAW = 1'b0;
    q  = cyc + 1;
    e2 = next_tick(q + 3);
    exp_q.push_back('{EV_DEC, e2 + 8});
    exp_q.push_back('{EV_STB, e2 + 8});
    repeat (30) @(negedge CLK);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL rst_evt missing kind=%0d exp_cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind != e.kind || o.cyc != e.cyc) begin
          failures++;
          $display("FAIL rst_evt got=%0d@%0d exp=%0d@%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL rst_extra got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_bounce();
    do_reset();
    checks++;
    if (DEC !== 1'b0) begin
      failures++; $display("FAIL bnc_dec0 got=%b exp=0", DEC);
    end
    BTN_RAW = 1'b1;
    repeat (6) @(negedge CLK);
    BTN_RAW = 1'b0;
    repeat (40) @(negedge CLK);
    checks += 2;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL bnc_events got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
    if (DEC !== 1'b0) begin
      failures++; $display("FAIL bnc_dec got=%b exp=0", DEC);
    end
  endtask

  task automatic test_short_press();
    ev_t e, o;
    drive_press(40, 40, 1'b0);
    checks++;
    if (DEC !== 1'b1) begin
      failures++; $display("FAIL short1_dec got=%b exp=1", DEC);
    end
    drive_press(40, 40, 1'b0);
    checks++;
    if (DEC !== 1'b0) begin
      failures++; $display("FAIL short2_dec got=%b exp=0", DEC);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL short_evt missing kind=%0d exp_cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind != e.kind || o.cyc != e.cyc) begin
          failures++;
          $display("FAIL short_evt got=%0d@%0d exp=%0d@%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL short_extra got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_long_press();
    ev_t e, o;
    drive_press(80, 40, 1'b1);
    checks += 2;
    if (DEC !== 1'b0) begin
      failures++; $display("FAIL long_dec got=%b exp=0", DEC);
    end
    if (BTN_STABLE !== 1'b0) begin
      failures++; $display("FAIL long_stable got=%b exp=0", BTN_STABLE);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL long_evt missing kind=%0d exp_cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind != e.kind || o.cyc != e.cyc) begin
          failures++;
          $display("FAIL long_evt got=%0d@%0d exp=%0d@%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL long_extra got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_release_glitch();
    int p, q, q2, e1, pr, n, t;
    ev_t e, o;
    BTN_RAW = 1'b1;
    p  = cyc + 1;
    e1 = next_tick(p + 3);
    pr = e1 + 8;
    exp_q.push_back('{EV_PRESS, pr});
    @(negedge CLK);
    while (cyc < pr + 2 || ((cyc - k) % TD) != 2) @(negedge CLK);
    BTN_RAW = 1'b0;
    q = cyc + 1;
    repeat (5) @(negedge CLK);
    BTN_RAW = 1'b1;
    // Ticks while debouncing the glitch do not advance the hold count.
    n = 0;
    t = pr;
    while (n < 10) begin
      t++;
      if (((t - k) % TD) == TD - 1 && !(t >= q + 2 && t <= q + 7)) n++;
    end
    exp_q.push_back('{EV_LONG, t});
    repeat (60) @(negedge CLK);
    checks += 2;
    if (DEC !== 1'b0) begin
      failures++; $display("FAIL glitch_dec got=%b exp=0", DEC);
    end
    if (BTN_STABLE !== 1'b1) begin
      failures++; $display("FAIL glitch_stable got=%b exp=1", BTN_STABLE);
    end
    BTN_RAW = 1'b0;
    q2 = cyc + 1;
    exp_q.push_back('{EV_STB, next_tick(q2 + 3) + 8});
    repeat (30) @(negedge CLK);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL glitch_evt missing kind=%0d exp_cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind != e.kind || o.cyc != e.cyc) begin
          failures++;
          $display("FAIL glitch_evt got=%0d@%0d exp=%0d@%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL glitch_extra got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid_release();
    int p, e1;
    ev_t e, o;
    BTN_RAW = 1'b1;
    p  = cyc + 1;
    e1 = next_tick(p + 3);
    exp_q.push_back('{EV_PRESS, e1 + 8});
    repeat (30) @(negedge CLK);
    BTN_RAW = 1'b0;
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    checks += 2;
    if (DEC !== 1'b0) begin
      failures++; $display("FAIL midrst_dec got=%b exp=0", DEC);
    end
    if (BTN_STABLE !== 1'b0) begin
      failures++; $display("FAIL midrst_stable got=%b exp=0", BTN_STABLE);
    end
    RESET = 1'b0;
    k = cyc + 1;
    repeat (40) @(negedge CLK);
    checks++;
    if (DEC !== 1'b0) begin
      failures++; $display("FAIL midrst_after_dec got=%b exp=0", DEC);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL midrst_evt missing kind=%0d exp_cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind != e.kind || o.cyc != e.cyc) begin
          failures++;
          $display("FAIL midrst_evt got=%0d@%0d exp=%0d@%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL midrst_extra got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    RESET   = 1'b1;
    BTN_RAW = 1'b0;
    test_reset();
    test_bounce();
    test_short_press();
    test_long_press();
    test_release_glitch();
    test_reset_mid_release();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
